// File: rtl/debounce_edge_gpi_core.sv
// Synchronized, debounced W-bit GPI slot with W1C rise/fall pending registers.
// Define DB_GPI_DEBOUNCE_EN for per-bit debounce counters and the PRD register.
module debounce_edge_gpi_core #(
  parameter int          W          = 8,
  parameter logic [15:0] DB_DEFAULT = 16'd50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  input  logic [W-1:0] din,
  output logic         irq
);

  localparam logic [4:0] A_DATA = 5'd0;
  localparam logic [4:0] A_RISE = 5'd1;
  localparam logic [4:0] A_FALL = 5'd2;
  localparam logic [4:0] A_IEN  = 5'd3;
  localparam logic [4:0] A_PRD  = 5'd4;

  logic [W-1:0] s1_q, s2_q;
  logic [W-1:0] db_q, db_d, dbp_q;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;
  logic [W-1:0] rien_q, rien_d;
  logic [W-1:0] fien_q, fien_d;
  logic [W-1:0] rise_set, fall_set;
  logic [W-1:0] rise_clr, fall_clr;
  logic         irq_q, irq_d;
  logic         we;
  logic [15:0]  prd_rd;
  logic         unused_ok;

  assign we = cs & write;

`ifdef DB_GPI_DEBOUNCE_EN
  logic [15:0]        prd_q, prd_d;
  logic [15:0]        peff_m1;
  logic [W-1:0][15:0] cnt_q, cnt_d;

  assign unused_ok = ^{read, wr_data};
  assign prd_rd    = prd_q;

  // P=0 behaves as P=1; >= ends a count overtaken by a smaller P
  assign peff_m1 = (prd_q == 16'd0) ? 16'd0 : prd_q - 16'd1;

  always_comb begin
    prd_d = prd_q;
    if (we && addr == A_PRD) prd_d = wr_data[15:0];
  end

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int i = 0; i < W; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = 16'd0;
      end else if (cnt_q[i] >= peff_m1) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = 16'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prd_q <= DB_DEFAULT;
      cnt_q <= '0;
    end else begin
      prd_q <= prd_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign unused_ok = ^{read, wr_data, DB_DEFAULT};
  assign prd_rd    = 16'd0;
  assign db_d      = s2_q;
`endif

  assign rise_set = db_q & ~dbp_q;
  assign fall_set = ~db_q & dbp_q;

  assign rise_clr = (we && addr == A_RISE) ? wr_data[W-1:0] : '0;
  assign fall_clr = (we && addr == A_FALL) ? wr_data[W-1:0] : '0;

  // set wins over a same-cycle W1C
  assign rise_d = (rise_q & ~rise_clr) | rise_set;
  assign fall_d = (fall_q & ~fall_clr) | fall_set;

  assign rien_d = (we && addr == A_IEN) ? wr_data[W-1:0] : rien_q;
  assign fien_d = (we && addr == A_IEN) ? wr_data[16+W-1:16] : fien_q;

  assign irq_d = |((rise_q & rien_q) | (fall_q & fien_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      dbp_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      rien_q <= '0;
      fien_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      db_q   <= db_d;
      dbp_q  <= db_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
      rien_q <= rien_d;
      fien_q <= fien_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (addr)
      A_DATA: rd_data[W-1:0] = db_q;
      A_RISE: rd_data[W-1:0] = rise_q;
      A_FALL: rd_data[W-1:0] = fall_q;
      A_IEN: begin
        rd_data[W-1:0]     = rien_q;
        rd_data[16+W-1:16] = fien_q;
      end
      A_PRD:   rd_data[15:0] = prd_rd;
      default: rd_data = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_debounce_edge_gpi_core.sv
// Directed bench for debounce_edge_gpi_core: register table plus timing sequences.
// Expectations follow DB_GPI_DEBOUNCE_EN the same way the design does.
module tb_debounce_edge_gpi_core;

  localparam int W = 8;
  localparam logic [15:0] DBD = 16'd20;

`ifdef DB_GPI_DEBOUNCE_EN
  localparam int          PE     = 4;
  localparam int          PDEF   = 20;
  localparam logic [31:0] PRD_RD = 32'd20;
  localparam logic [31:0] PRD_7  = 32'd7;
  localparam logic        GLITCH = 1'b0;
`else
  localparam int          PE     = 1;
  localparam int          PDEF   = 1;
  localparam logic [31:0] PRD_RD = 32'd0;
  localparam logic [31:0] PRD_7  = 32'd0;
  localparam logic        GLITCH = 1'b1;
`endif

  logic         clk;
  logic         reset_n;
  logic         cs;
  logic         read;
  logic         write;
  logic [4:0]   addr;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data;
  logic [W-1:0] din;
  logic         irq;

  int n_chk;
  int n_err;

  debounce_edge_gpi_core #(.W(W), .DB_DEFAULT(DBD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .din     (din),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] e;
    string       nm;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    cs   = 1'b1;
    read = 1'b1;
    #1;
    d    = rd_data;
    cs   = 1'b0;
    read = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr    = a;
    wr_data = d;
    cs      = 1'b1;
    write   = 1'b1;
    tick();
    cs      = 1'b0;
    write   = 1'b0;
  endtask

  logic [31:0] v;
  logic [31:0] v2;
  int f_db, f_rise, f_irq, f_r3;
  logic seen;

  initial begin
    n_chk   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    cs      = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    wr_data = '0;
    din     = '0;

    tv[0]  = '{1'b0, 5'd0, 32'h0, 32'h0,         "rst_data"};
    tv[1]  = '{1'b0, 5'd1, 32'h0, 32'h0,         "rst_rise"};
    tv[2]  = '{1'b0, 5'd2, 32'h0, 32'h0,         "rst_fall"};
    tv[3]  = '{1'b0, 5'd3, 32'h0, 32'h0,         "rst_ien"};
    tv[4]  = '{1'b0, 5'd4, 32'h0, PRD_RD,        "rst_prd"};
    tv[5]  = '{1'b0, 5'd7, 32'h0, 32'h0,         "rd_addr7"};
    tv[6]  = '{1'b1, 5'd3, 32'hFFFF_FFFF, 32'h0, "wr_ien"};
    tv[7]  = '{1'b0, 5'd3, 32'h0, 32'h00FF_00FF, "ien_rb"};
    tv[8]  = '{1'b1, 5'd4, 32'h1234_0007, 32'h0, "wr_prd"};
    tv[9]  = '{1'b0, 5'd4, 32'h0, PRD_7,         "prd_rb"};
    tv[10] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, "wr_data"};
    tv[11] = '{1'b0, 5'd0, 32'h0, 32'h0,         "data_ro"};
    tv[12] = '{1'b1, 5'd9, 32'hFFFF_FFFF, 32'h0, "wr_addr9"};
    tv[13] = '{1'b0, 5'd9, 32'h0, 32'h0,         "rd_addr9"};
    tv[14] = '{1'b1, 5'd3, 32'h0, 32'h0,         "wr_ien0"};
    tv[15] = '{1'b0, 5'd3, 32'h0, 32'h0,         "ien_zero"};

    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_irq", {31'b0, irq}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      if (tv[i].wr) begin
        wr(tv[i].a, tv[i].d);
      end else begin
        rd(tv[i].a, v);
        chk(tv[i].nm, v, tv[i].e);
      end
    end

    // debounce latency on bit 0 with rise irq enabled
    wr(5'd4, 32'd4);
    wr(5'd3, 32'h1);
    din[0] = 1'b1;
    f_db = 0; f_rise = 0; f_irq = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      rd(5'd0, v);
      rd(5'd1, v2);
      if (v[0] && f_db == 0) f_db = e;
      if (v2[0] && f_rise == 0) f_rise = e;
      if (irq && f_irq == 0) f_irq = e;
    end
    chk("lat_data", f_db, PE + 2);
    chk("lat_rise", f_rise, PE + 3);
    chk("lat_irq", f_irq, PE + 4);
    wr(5'd1, 32'h1);
    rd(5'd1, v);
    chk("rise_w1c", v, 32'h0);
    tick();
    chk("rise_irq_off", {31'b0, irq}, 32'h0);

    // 3-cycle glitch on bit 2
    din[2] = 1'b1;
    repeat (3) tick();
    din[2] = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick();
      rd(5'd0, v);
      if (v[2]) seen = 1'b1;
    end
    chk("glitch_data", {31'b0, seen}, {31'b0, GLITCH});
    rd(5'd1, v);
    chk("glitch_rise", v, GLITCH ? 32'h4 : 32'h0);
    rd(5'd2, v);
    chk("glitch_fall", v, GLITCH ? 32'h4 : 32'h0);
    chk("glitch_irq", {31'b0, irq}, 32'h0);
    wr(5'd1, 32'hFF);
    wr(5'd2, 32'hFF);

    // fall edge on bit 1 with fall irq enabled, then W1C
    din[1] = 1'b1;
    repeat (PE + 6) tick();
    rd(5'd0, v);
    chk("fall_pre_data", v, 32'h3);
    wr(5'd1, 32'h2);
    wr(5'd3, 32'h0002_0000);
    din[1] = 1'b0;
    repeat (PE + 3) tick();
    chk("fall_irq_early", {31'b0, irq}, 32'h0);
    tick();
    rd(5'd2, v);
    chk("fall_pend", v, 32'h2);
    chk("fall_irq", {31'b0, irq}, 32'h1);
    wr(5'd2, 32'h2);
    rd(5'd2, v);
    chk("fall_w1c", v, 32'h0);
    tick();
    chk("fall_irq_off", {31'b0, irq}, 32'h0);

    // W1C on the same edge that latches a new rise on bit 0
    din[0] = 1'b0;
    repeat (PE + 6) tick();
    wr(5'd2, 32'hFF);
    wr(5'd3, 32'h0);
    din[0] = 1'b1;
    repeat (PE + 2) tick();
    wr(5'd1, 32'h1);
    rd(5'd1, v);
    chk("collide_set_wins", v, 32'h1);
    wr(5'd1, 32'h1);
    rd(5'd1, v);
    chk("collide_then_clr", v, 32'h0);

    // reset in the middle of a long debounce on bit 3
    wr(5'd4, 32'd100);
    for (int c = 0; c < 50; c++) begin
      din[3] = ((c / 7) % 2) != 0;
      tick();
    end
    din[3]  = 1'b1;
    reset_n = 1'b0;
    rd(5'd0, v);
    chk("mid_rst_data", v, 32'h0);
    rd(5'd4, v);
    chk("mid_rst_prd", v, PRD_RD);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    f_r3 = 0;
    for (int e = 1; e <= PDEF + 10; e++) begin
      tick();
      rd(5'd0, v);
      if (v[3] && f_r3 == 0) f_r3 = e;
    end
    chk("post_rst_lat", f_r3, PDEF + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
